// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_pkg
//  Purpose  : Shared types, default geometry and helpers for the vector
//             register file (read-stream state encoding, length clamp).
//  Revision : 1.0  initial release
// ============================================================================
package vrf_pkg;

    // Default geometry: 8 registers x 64 elements x 64 bits
    localparam int VRF_DATA  = 64;
    localparam int VRF_ADDR  = 6;
    localparam int VRF_NREG  = 8;
    localparam int VRF_DEPTH = 2 ** VRF_ADDR;
    localparam int VRF_RB    = $clog2(VRF_NREG);

    // Read stream states: RUN issues RAM reads, DRAIN waits for the last
    // element to be taken by the consumer.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    // Requested vector lengths above the register depth use the full depth.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vrf_read_stream.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_read_stream
//  Purpose  : One streaming read port: element counters, RUN/DRAIN state,
//             one-entry skid register behind the 1-cycle RAM read, and the
//             optional chaining gate (macro VRF_CHAIN_EN) that holds issue of
//             element i until the write stream has reached it.
//  Ports    : clk, rst_n              clock / synchronous active-low reset
//             start_i, reg_i, len_i   accepted start (len already clamped)
//             w_busy_i, w_reg_i,
//             w_cnt_i, wr_en_i        write-stream progress for chaining
//             rd_en_o, rd_addr_o      RAM read request ({reg, element})
//             ram_data_i              RAM output, valid 1 cycle after rd_en_o
//             valid_o, ready_i,
//             data_o                  element handshake to the consumer
//             busy_o, done_o          stream active / last element taken
//  Revision : 1.0  initial release
// ============================================================================
module vrf_read_stream
    import vrf_pkg::*;
#(
    parameter int DATA = VRF_DATA,
    parameter int ADDR = VRF_ADDR,
    parameter int RB   = VRF_RB
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [RB-1:0]      reg_i,
    input  logic [ADDR:0]      len_i,
    input  logic               w_busy_i,
    input  logic [RB-1:0]      w_reg_i,
    input  logic [ADDR:0]      w_cnt_i,
    input  logic               wr_en_i,
    output logic               rd_en_o,
    output logic [RB+ADDR-1:0] rd_addr_o,
    input  logic [DATA-1:0]    ram_data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DATA-1:0]    data_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [ADDR:0] CNT_ONE = (ADDR+1)'(1);

    rd_state_t          state_q;
    logic [RB-1:0]      reg_q;
    logic [ADDR:0]      len_q;
    logic [ADDR:0]      iss_q;      // elements issued to the RAM
    logic [ADDR:0]      acc_q;      // elements taken by the consumer
    logic               pipe_v_q;   // RAM output register holds an element
    logic               skid_v_q;
    logic [DATA-1:0]    skid_q;
    logic               done_q;
    logic               chain_ok;
    logic               accept;

`ifdef VRF_CHAIN_EN
    // Element i may issue once the write counter has passed it, or in the
    // very cycle it is written (the RAM forwards write data on a collision).
    assign chain_ok = !(w_busy_i && (w_reg_i == reg_q)) ||
                      (w_cnt_i > iss_q) ||
                      (wr_en_i && (w_cnt_i == iss_q));
`else
    assign chain_ok = 1'b1;
    logic unused_chain;
    assign unused_chain = ^{w_busy_i, w_reg_i, w_cnt_i, wr_en_i};
`endif

    // Issue depends only on registered state, never on ready_i: the skid
    // register absorbs the element already in flight when ready drops.
    assign rd_en_o   = (state_q == RD_RUN) && (iss_q != len_q) && !skid_v_q && chain_ok;
    assign rd_addr_o = {reg_q, iss_q[ADDR-1:0]};

    // The skid register always holds the older element, so it goes first.
    assign valid_o = skid_v_q | pipe_v_q;
    assign data_o  = skid_v_q ? skid_q : (pipe_v_q ? ram_data_i : '0);
    assign accept  = valid_o & ready_i;
    assign busy_o  = (state_q != RD_IDLE);
    assign done_o  = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RD_IDLE;
            reg_q    <= '0;
            len_q    <= '0;
            iss_q    <= '0;
            acc_q    <= '0;
            pipe_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            skid_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // While the skid is full nothing issues, so the RAM output
            // register keeps its element until the skid drains.
            if (rd_en_o) begin
                pipe_v_q <= 1'b1;
            end else if (!skid_v_q) begin
                pipe_v_q <= 1'b0;
            end

            if (skid_v_q) begin
                if (ready_i) begin
                    skid_v_q <= 1'b0;
                end
            end else if (pipe_v_q && !ready_i) begin
                skid_v_q <= 1'b1;
                skid_q   <= ram_data_i;
            end

            if (rd_en_o) begin
                iss_q <= iss_q + CNT_ONE;
            end
            if (accept) begin
                acc_q <= acc_q + CNT_ONE;
            end

            case (state_q)
                RD_IDLE: begin
                    if (start_i) begin
                        reg_q   <= reg_i;
                        len_q   <= len_i;
                        iss_q   <= '0;
                        acc_q   <= '0;
                        state_q <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (len_q == '0) begin
                        state_q <= RD_IDLE;
                        done_q  <= 1'b1;
                    end else if (rd_en_o && (iss_q + CNT_ONE == len_q)) begin
                        state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (accept && (acc_q + CNT_ONE == len_q)) begin
                        state_q <= RD_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : vector_register_file
//  Purpose  : NREG x DEPTH x DATA vector register file with one streaming
//             write port and two independent streaming read ports. Storage
//             is replicated per read port; the write stream updates both.
//             Macro VRF_CHAIN_EN: a read of the register being written is
//             chained behind the write instead of being rejected.
//  Ports    : clk, rst_n                 clock / synchronous active-low reset
//             w_start_i, w_reg_i,
//             w_len_i, w_valid_i,
//             w_data_i                   write stream control and elements
//             w_busy_o, w_done_o         write stream status
//             rK_start_i, rK_reg_i,
//             rK_len_i, rK_ready_i       read stream K control (K = 0, 1)
//             rK_valid_o, rK_data_o,
//             rK_busy_o, rK_done_o       read stream K elements and status
//             conflict_o                 a read start was rejected
//  Revision : 1.0  initial release
// ============================================================================
module vector_register_file
    import vrf_pkg::*;
#(
    parameter  int DATA = VRF_DATA,
    parameter  int ADDR = VRF_ADDR,
    parameter  int NREG = VRF_NREG,
    localparam int RB   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            w_start_i,
    input  logic [RB-1:0]   w_reg_i,
    input  logic [ADDR:0]   w_len_i,
    input  logic            w_valid_i,
    input  logic [DATA-1:0] w_data_i,
    output logic            w_busy_o,
    output logic            w_done_o,
    input  logic            r0_start_i,
    input  logic [RB-1:0]   r0_reg_i,
    input  logic [ADDR:0]   r0_len_i,
    output logic            r0_valid_o,
    input  logic            r0_ready_i,
    output logic [DATA-1:0] r0_data_o,
    output logic            r0_busy_o,
    output logic            r0_done_o,
    input  logic            r1_start_i,
    input  logic [RB-1:0]   r1_reg_i,
    input  logic [ADDR:0]   r1_len_i,
    output logic            r1_valid_o,
    input  logic            r1_ready_i,
    output logic [DATA-1:0] r1_data_o,
    output logic            r1_busy_o,
    output logic            r1_done_o,
    output logic            conflict_o
);

    localparam int          DEPTH   = 2 ** ADDR;
    localparam int          AW      = RB + ADDR;
    localparam int          MEMW    = 2 ** AW;
    localparam logic [ADDR:0] CNT_ONE = (ADDR+1)'(1);

    // ------------------------------------------------------------------
    // Write stream
    // ------------------------------------------------------------------
    logic            w_busy_q;
    logic            w_done_q;
    logic [RB-1:0]   w_reg_q;
    logic [ADDR:0]   w_len_q;
    logic [ADDR:0]   w_cnt_q;
    logic            wr_en;
    logic            w_last;
    logic [AW-1:0]   wr_addr;

    // The counter stops at len, so a zero-length stream never writes.
    assign wr_en   = w_busy_q && w_valid_i && (w_cnt_q != w_len_q);
    assign wr_addr = {w_reg_q, w_cnt_q[ADDR-1:0]};
    assign w_last  = (w_len_q == '0) || (wr_en && (w_cnt_q + CNT_ONE == w_len_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_busy_q <= 1'b0;
            w_done_q <= 1'b0;
            w_reg_q  <= '0;
            w_len_q  <= '0;
            w_cnt_q  <= '0;
        end else begin
            w_done_q <= 1'b0;
            if (!w_busy_q) begin
                if (w_start_i) begin
                    w_busy_q <= 1'b1;
                    w_reg_q  <= w_reg_i;
                    w_len_q  <= (ADDR+1)'(clamp_len(32'(w_len_i), DEPTH));
                    w_cnt_q  <= '0;
                end
            end else begin
                if (wr_en) begin
                    w_cnt_q <= w_cnt_q + CNT_ONE;
                end
                if (w_last) begin
                    w_busy_q <= 1'b0;
                    w_done_q <= 1'b1;
                end
            end
        end
    end

    assign w_busy_o = w_busy_q;
    assign w_done_o = w_done_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic            rd_start [2];
    logic [RB-1:0]   rd_reg   [2];
    logic [ADDR:0]   rd_len   [2];
    logic            rd_ready [2];
    logic            rd_go    [2];
    logic            rd_rej   [2];
    logic            rd_en    [2];
    logic [AW-1:0]   rd_addr  [2];
    logic [DATA-1:0] ram_q    [2];
    logic            rd_valid [2];
    logic [DATA-1:0] rd_data  [2];
    logic            rd_busy  [2];
    logic            rd_done  [2];
    logic            conflict_q;

    assign rd_start[0] = r0_start_i;
    assign rd_start[1] = r1_start_i;
    assign rd_reg[0]   = r0_reg_i;
    assign rd_reg[1]   = r1_reg_i;
    assign rd_len[0]   = r0_len_i;
    assign rd_len[1]   = r1_len_i;
    assign rd_ready[0] = r0_ready_i;
    assign rd_ready[1] = r1_ready_i;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_rd
`ifdef VRF_CHAIN_EN
            assign rd_go[k]  = rd_start[k];
            assign rd_rej[k] = 1'b0;
`else
            // Only a start the idle port would otherwise accept can conflict.
            assign rd_rej[k] = rd_start[k] && !rd_busy[k] && w_busy_q &&
                               (rd_reg[k] == w_reg_q);
            assign rd_go[k]  = rd_start[k] && !rd_rej[k];
`endif

            // Private copy of the storage for this port; write-first on a
            // same-address collision.
            logic [DATA-1:0] mem_q [MEMW];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wr_addr] <= w_data_i;
                end
                if (rd_en[k]) begin
                    ram_q[k] <= (wr_en && (wr_addr == rd_addr[k])) ? w_data_i
                                                                   : mem_q[rd_addr[k]];
                end
            end

            vrf_read_stream #(
                .DATA (DATA),
                .ADDR (ADDR),
                .RB   (RB)
            ) u_rd (
                .clk        (clk),
                .rst_n      (rst_n),
                .start_i    (rd_go[k]),
                .reg_i      (rd_reg[k]),
                .len_i      ((ADDR+1)'(clamp_len(32'(rd_len[k]), DEPTH))),
                .w_busy_i   (w_busy_q),
                .w_reg_i    (w_reg_q),
                .w_cnt_i    (w_cnt_q),
                .wr_en_i    (wr_en),
                .rd_en_o    (rd_en[k]),
                .rd_addr_o  (rd_addr[k]),
                .ram_data_i (ram_q[k]),
                .valid_o    (rd_valid[k]),
                .ready_i    (rd_ready[k]),
                .data_o     (rd_data[k]),
                .busy_o     (rd_busy[k]),
                .done_o     (rd_done[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= rd_rej[0] | rd_rej[1];
        end
    end

    assign conflict_o = conflict_q;
    assign r0_valid_o = rd_valid[0];
    assign r0_data_o  = rd_data[0];
    assign r0_busy_o  = rd_busy[0];
    assign r0_done_o  = rd_done[0];
    assign r1_valid_o = rd_valid[1];
    assign r1_data_o  = rd_data[1];
    assign r1_busy_o  = rd_busy[1];
    assign r1_done_o  = rd_done[1];

endmodule
`default_nettype wire
